// File: rtl/receptor_mdio.sv
// MDIO responder: decodes 32-bit management frames on MDC/MDIO and services them from a
// small 16-bit register file. Optional preamble check enabled by MDIO_PREAMBLE_EN.
module receptor_mdio #(
  parameter logic [4:0] PHY_ADDR = 5'h01,
  parameter int         NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic        mdio_in_oe,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WR_TA, S_WR_DATA, S_RD_TA, S_RD_DATA, S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] rd_word_q, rd_word_d;
  logic        mdc_q;
  logic        mdio_in_q, mdio_in_d;
  logic        mdio_in_oe_q, mdio_in_oe_d;
  logic        wr_stb_q, wr_stb_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] regs_q [NUM_REGS];
  logic [15:0] regs_d [NUM_REGS];
`ifdef MDIO_PREAMBLE_EN
  logic [5:0]  ones_q, ones_d;
`endif

  logic        mdio_line, rise, fall, start;
  logic [13:0] hdr;
  logic [15:0] word, rd_sel;

  assign mdio_line = mdio_oe ? mdio_out : 1'b1;
  assign rise      = mdc & ~mdc_q;
  assign fall      = ~mdc & mdc_q;
  assign hdr       = {sr_q[12:0], mdio_line};
  assign word      = {sr_q[14:0], mdio_line};

  // Unimplemented addresses read back as all ones.
  always_comb begin
    rd_sel = 16'hFFFF;
    for (int i = 0; i < NUM_REGS; i++)
      if (5'(i) == hdr[4:0]) rd_sel = regs_q[i];
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    regad_d      = regad_q;
    rd_word_d    = rd_word_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_oe_d = mdio_in_oe_q;
    wr_stb_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_err_d  = 1'b0;
    regs_d       = regs_q;
    start        = 1'b0;
`ifdef MDIO_PREAMBLE_EN
    ones_d       = ones_q;
`endif
    case (state_q)
      S_IDLE: if (fall) begin
`ifdef MDIO_PREAMBLE_EN
        if (mdio_line) ones_d = (ones_q == 6'd32) ? 6'd32 : ones_q + 6'd1;
        else begin
          ones_d = 6'd0;
          start  = (ones_q == 6'd32);
        end
`else
        start = ~mdio_line;
`endif
        if (start) begin
          state_d   = S_HDR;
          bit_cnt_d = 6'd1;
          sr_d      = 16'h0;
        end
      end
      S_HDR: if (fall) begin
        sr_d      = word;
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd13) begin
          regad_d = hdr[4:0];
          if (hdr[13:12] != 2'b01 || hdr[11:10] == 2'b00 || hdr[11:10] == 2'b11) begin
            frame_err_d = 1'b1;
            state_d     = S_SKIP;
          end else if (hdr[9:5] != PHY_ADDR) begin
            state_d = S_SKIP;
          end else if (hdr[11:10] == 2'b01) begin
            state_d = S_WR_TA;
          end else begin
            state_d   = S_RD_TA;
            rd_word_d = rd_sel;
          end
        end
      end
      S_WR_TA: if (fall) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd15) state_d = S_WR_DATA;
      end
      S_WR_DATA: if (fall) begin
        sr_d      = word;
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd31) begin
          wr_stb_d  = 1'b1;
          wr_addr_d = regad_q;
          wr_data_d = word;
          for (int i = 0; i < NUM_REGS; i++)
            if (5'(i) == regad_q) regs_d[i] = word;
          state_d   = S_IDLE;
          bit_cnt_d = 6'd0;
        end
      end
      // Read side counts MDC rises: 14 -> TA1 (stay off), 15 -> TA2 (drive 0).
      S_RD_TA: if (rise) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd15) begin
          mdio_in_oe_d = 1'b1;
          mdio_in_d    = 1'b0;
          state_d      = S_RD_DATA;
        end
      end
      S_RD_DATA: if (rise) begin
        if (bit_cnt_q == 6'd32) begin
          mdio_in_oe_d = 1'b0;
          mdio_in_d    = 1'b1;
          state_d      = S_IDLE;
          bit_cnt_d    = 6'd0;
        end else begin
          mdio_in_d = rd_word_q[~bit_cnt_q[3:0]];
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      S_SKIP: if (fall) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd31) begin
          state_d   = S_IDLE;
          bit_cnt_d = 6'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) mdc_q <= mdc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 6'd0;
      sr_q         <= 16'h0;
      regad_q      <= 5'h0;
      rd_word_q    <= 16'h0;
      mdio_in_q    <= 1'b1;
      mdio_in_oe_q <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= 5'h0;
      wr_data_q    <= 16'h0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0;
`ifdef MDIO_PREAMBLE_EN
      ones_q       <= 6'd0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      regad_q      <= regad_d;
      rd_word_q    <= rd_word_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_oe_q <= mdio_in_oe_d;
      wr_stb_q     <= wr_stb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_err_q  <= frame_err_d;
      regs_q       <= regs_d;
`ifdef MDIO_PREAMBLE_EN
      ones_q       <= ones_d;
`endif
    end
  end

  assign mdio_in    = mdio_in_q;
  assign mdio_in_oe = mdio_in_oe_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_err  = frame_err_q;

endmodule
